// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage access unit: bus widths, FSM encoding,
// the timeout load value and the stall-bus position of the MEM stage.
package mem_access_stage_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int REG_BUS      = 32;
    localparam int MEM_BUS      = 32;
    localparam int MEM_ADDR_BUS = 32;

    localparam logic [MEM_BUS-1:0] ERR_DATA = 32'hDEAD_BEEF;

    localparam int STALL_IDX_MEM = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

    // Counter width for a terminal count of TIMEOUT-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle counter for the data-memory access: cleared at launch, counts
// each un-acknowledged BUSY cycle and flags the last permitted one.
module mem_timeout_cnt
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int              W  = cnt_width(TIMEOUT);
    localparam logic [W-1:0]    TC = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Holds at the terminal count; the FSM leaves BUSY on that cycle anyway.
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_tc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: launches one req/ack transaction per memory
// instruction, stalls the pipeline while it is outstanding, merges load data.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [REG_ADDR_BUS-1:0] i_mem_waddr,
    input  logic                    i_mem_we,
    input  logic [REG_BUS-1:0]      i_mem_wdata,
    input  logic                    i_mem_mre,
    input  logic                    i_mem_mwe,
    input  logic [MEM_BUS-1:0]      i_mem_mwdata,
    input  logic [MEM_ADDR_BUS-1:0] i_mem_maddr,

    output logic                    o_dm_req,
    output logic                    o_dm_we,
    output logic [MEM_ADDR_BUS-1:0] o_dm_addr,
    output logic [MEM_BUS-1:0]      o_dm_wdata,
    input  logic                    i_dm_ack,
    input  logic [MEM_BUS-1:0]      i_dm_rdata,

    output logic                    o_stallreq_mem,

    output logic [REG_ADDR_BUS-1:0] o_wb_waddr,
    output logic                    o_wb_we,
    output logic [REG_BUS-1:0]      o_wb_wdata,

    output logic                    o_dm_err
);

    mem_state_t              r_state;
    logic                    r_dm_req;
    logic                    r_dm_we;
    logic [MEM_ADDR_BUS-1:0] r_dm_addr;
    logic [MEM_BUS-1:0]      r_dm_wdata;
    logic [MEM_BUS-1:0]      r_rdata;
    logic                    r_dm_err;

    logic w_access;
    logic w_launch;
    logic w_busy;
    logic w_tc;
    logic w_stall;

    assign w_access = i_mem_mre | i_mem_mwe;
    assign w_launch = (r_state == ST_IDLE) && w_access;
    assign w_busy   = (r_state == ST_BUSY);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_launch),
        .i_en  (w_busy && !i_dm_ack),
        .o_tc  (w_tc)
    );

    // A store wins when both mre and mwe are set: dm_we simply takes mwe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_rdata    <= '0;
            r_dm_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= i_mem_mwe;
                        r_dm_addr  <= i_mem_maddr;
                        r_dm_wdata <= i_mem_mwdata;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_dm_ack) begin
                        r_rdata  <= i_dm_rdata;
                        r_dm_req <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (w_tc) begin
                        r_rdata  <= ERR_DATA;
                        r_dm_err <= 1'b1;
                        r_dm_req <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_dm_req <= 1'b0;
                end
            endcase
        end
    end

    // Stall is gated by rst so a held access does not stall ctrl during reset.
    assign w_stall = !rst && (w_launch || w_busy);

    always_comb begin
        o_wb_waddr = i_mem_waddr;
        o_wb_we    = i_mem_we;
        o_wb_wdata = i_mem_wdata;
        if (w_stall) begin
            o_wb_we    = 1'b0;
            o_wb_wdata = '0;
        end else if ((r_state == ST_DONE) && !r_dm_we) begin
            o_wb_wdata = r_rdata;
        end
    end

    assign o_stallreq_mem = w_stall;
    assign o_dm_req       = r_dm_req;
    assign o_dm_we        = r_dm_we;
    assign o_dm_addr      = r_dm_addr;
    assign o_dm_wdata     = r_dm_wdata;
    assign o_dm_err       = r_dm_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// instruction stream checked against a transaction-level model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        mem_mre;
    logic        mem_mwe;
    logic [31:0] mem_mwdata;
    logic [31:0] mem_maddr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stallreq_mem;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        dm_err;

    int   checks = 0;
    int   errors = 0;
    logic model_err = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_waddr    (mem_waddr),
        .i_mem_we       (mem_we),
        .i_mem_wdata    (mem_wdata),
        .i_mem_mre      (mem_mre),
        .i_mem_mwe      (mem_mwe),
        .i_mem_mwdata   (mem_mwdata),
        .i_mem_maddr    (mem_maddr),
        .o_dm_req       (dm_req),
        .o_dm_we        (dm_we),
        .o_dm_addr      (dm_addr),
        .o_dm_wdata     (dm_wdata),
        .i_dm_ack       (dm_ack),
        .i_dm_rdata     (dm_rdata),
        .o_stallreq_mem (stallreq_mem),
        .o_wb_waddr     (wb_waddr),
        .o_wb_we        (wb_we),
        .o_wb_wdata     (wb_wdata),
        .o_dm_err       (dm_err)
    );

    // One instruction held in EX/MEM until the stage lets it go. ack_k is the
    // BUSY cycle in which memory answers; 0 or >TO means it never does.
    task automatic run_instr(input string name, input logic [4:0] wa, input logic we,
                             input logic [31:0] wd, input logic mre, input logic mwe,
                             input logic [31:0] ma, input logic [31:0] mwd,
                             input int ack_k, input logic [31:0] rd);
        logic        access, is_load, acked, done, prev_req, bubble_bad, req_bad;
        int          exp_stall, stall_cnt, busy, reqs;
        logic [31:0] exp_wd;
        access    = mre | mwe;
        is_load   = mre & ~mwe;
        acked     = access && (ack_k >= 1) && (ack_k <= TO);
        exp_stall = !access ? 0 : (acked ? ack_k + 1 : TO + 1);
        exp_wd    = is_load ? (acked ? rd : ERR_DATA) : wd;
        if (access && !acked) model_err = 1'b1;

        mem_waddr = wa; mem_we = we; mem_wdata = wd;
        mem_mre = mre; mem_mwe = mwe; mem_maddr = ma; mem_mwdata = mwd;
        done = 0; stall_cnt = 0; busy = 0; reqs = 0;
        prev_req = dm_req; bubble_bad = 0; req_bad = 0;

        for (int cyc = 0; cyc < TO + 10 && !done; cyc++) begin
            @(negedge clk);
            if (stallreq_mem) begin
                stall_cnt++;
                if (wb_we !== 1'b0 || wb_wdata !== 32'h0) bubble_bad = 1;
                if (dm_req) begin
                    busy++;
                    if (dm_we !== mwe || dm_addr !== ma || dm_wdata !== mwd) req_bad = 1;
                    if (busy == ack_k) begin
                        dm_ack = 1'b1;
                        dm_rdata = rd;
                    end
                end
            end else begin
                done = 1;
                checks++;
                if (wb_waddr !== wa || wb_we !== we || wb_wdata !== exp_wd) begin
                    errors++;
                    $display("FAIL %s wb: got addr=%0d we=%0b data=%h, want addr=%0d we=%0b data=%h",
                             name, wb_waddr, wb_we, wb_wdata, wa, we, exp_wd);
                end
                checks++;
                if (dm_req !== 1'b0 || dm_err !== model_err) begin
                    errors++;
                    $display("FAIL %s done_state: got dm_req=%0b dm_err=%0b, want dm_req=0 dm_err=%0b",
                             name, dm_req, dm_err, model_err);
                end
            end
            if (dm_req && !prev_req) reqs++;
            prev_req = dm_req;
            if (!done) begin
                @(posedge clk);
                #1;
                dm_ack = 1'b0;
            end
        end
        // Leave the instruction held through the DONE edge, then hand back at edge+1.
        @(posedge clk);
        #1;
        dm_ack = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s no_completion: stage still stalling after %0d cycles, want release", name, TO + 10);
        end
        checks++;
        if (stall_cnt != exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, want %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (reqs != (access ? 1 : 0)) begin
            errors++;
            $display("FAIL %s request_count: got %0d, want %0d", name, reqs, access ? 1 : 0);
        end
        checks++;
        if (bubble_bad || req_bad) begin
            errors++;
            $display("FAIL %s bus_or_bubble: got bubble_bad=%0b req_unstable=%0b, want 0 0",
                     name, bubble_bad, req_bad);
        end
    endtask

    task automatic idle_inputs();
        mem_waddr = '0; mem_we = 0; mem_wdata = '0;
        mem_mre = 0; mem_mwe = 0; mem_maddr = '0; mem_mwdata = '0;
    endtask

    task automatic test_reset();
        rst = 1; dm_ack = 0; dm_rdata = '0;
        idle_inputs();
        mem_mre = 1; mem_maddr = 32'h0000_0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dm_req !== 0 || stallreq_mem !== 0 || dm_err !== 0) begin
            errors++;
            $display("FAIL reset_values: got dm_req=%0b stall=%0b err=%0b, want 0 0 0", dm_req, stallreq_mem, dm_err);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (dm_req !== 1 || dm_addr !== 32'h0000_0100 || dm_we !== 0) begin
            errors++;
            $display("FAIL reset_release_launch: got req=%0b addr=%h we=%0b, want 1 00000100 0", dm_req, dm_addr, dm_we);
        end
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        model_err = 0;
    endtask

    task automatic test_load();
        run_instr("load_ack1", 5'd3, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678);
    endtask

    task automatic test_store();
        run_instr("store_ack4", 5'd9, 1'b0, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4, 32'h0);
    endtask

    task automatic test_alu();
        run_instr("alu", 5'd7, 1'b1, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_instr("ack_at_limit", 5'd4, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, TO, 32'hCAFE_0001);
        run_instr("timeout", 5'd5, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 0, 32'h0);
        idle_inputs();
        @(negedge clk);
        dm_ack = 1; dm_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dm_ack = 0;
        @(negedge clk);
        checks++;
        if (dm_req !== 0 || stallreq_mem !== 0 || dm_err !== 1) begin
            errors++;
            $display("FAIL late_ack: got req=%0b stall=%0b err=%0b, want 0 0 1", dm_req, stallreq_mem, dm_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_load", 5'd12, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 32'h0BAD_F00D);
        run_instr("b2b_store", 5'd13, 1'b0, 32'h55, 1'b1, 1'b1, 32'h0000_0204, 32'h7777_8888, 1, 32'h0);
    endtask

    task automatic test_reset_mid_busy();
        mem_waddr = 5'd2; mem_we = 1; mem_mre = 1; mem_mwe = 0; mem_maddr = 32'h0000_0300;
        repeat (3) @(posedge clk);
        #1;
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        rst = 0; model_err = 0;
        checks++;
        if (dm_req !== 0 || dm_err !== 0) begin
            errors++;
            $display("FAIL reset_mid_busy: got req=%0b err=%0b, want 0 0", dm_req, dm_err);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dm_req !== 0 || stallreq_mem !== 0) begin
            errors++;
            $display("FAIL no_retry: got req=%0b stall=%0b, want 0 0", dm_req, stallreq_mem);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, k;
            kind = $urandom_range(0, 3);
            k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 5);
            run_instr("random", 5'($urandom), 1'($urandom), $urandom,
                      (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                      {$urandom_range(0, 1023), 2'b00}, $urandom, k, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage access unit sitting between the EX/MEM pipeline register and a variable-latency data memory. It consumes a memory-access packet from EX/MEM and issues one request/acknowledge transaction on the data-memory bus. While the access is outstanding it raises a stall request to ctrl. It presents the write-back packet, with load data merged in, to the MEM/WB register.

## Interface
- TIMEOUT, 15: maximum BUSY cycles allowed without dm_ack before the access is abandoned (1..255).
- ERR_DATA, 32'hDEAD_BEEF: load data returned on timeout.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_waddr  in  5  destination register address from EX/MEM
- mem_we  in  1  register write enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_mre  in  1  load request
- mem_mwe  in  1  store request
- mem_mwdata  in  32  store data
- mem_maddr  in  32  byte address, word aligned
- dm_req  out  1  bus request, registered
- dm_we  out  1  1 = store, 0 = load, registered
- dm_addr  out  32  registered
- dm_wdata  out  32  registered
- dm_ack  in  1  one-cycle completion pulse from memory
- dm_rdata  in  32  load data, valid with dm_ack
- stallreq_mem  out  1  stall request to ctrl (bit 4 of the stall bus)
- wb_waddr  out  5  to MEM/WB
- wb_we  out  1  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- dm_err  out  1  sticky timeout flag; cleared only by rst

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE
  - If mem_mre|mem_mwe, stallreq_mem=1 combinationally. On the next edge: dm_req<=1, dm_we<=mem_mwe, dm_addr<=mem_maddr, dm_wdata<=mem_mwdata, timeout counter<=0, state<=BUSY.
  - If mem_mre and mem_mwe are both set, the access is treated as a store.
  - With no access: stallreq_mem=0, and wb_* pass mem_waddr/mem_we/mem_wdata through.
- BUSY
  - stallreq_mem=1, dm_req held at 1.
  - On dm_ack: rdata_q<=dm_rdata, dm_req<=0, state<=DONE.
  - On no ack: the counter increments. When the counter reaches TIMEOUT-1 without ack: rdata_q<=ERR_DATA, dm_err<=1, dm_req<=0, state<=DONE.
  - If dm_ack and the timeout arrive in the same cycle, the ack wins.
- DONE
  - stallreq_mem=0. The pipeline advances at the end of this cycle. The EX/MEM inputs still hold the same instruction throughout the stall.
  - wb_waddr=mem_waddr, wb_we=mem_we. wb_wdata=rdata_q if the access was a load, else mem_wdata.
  - state<=IDLE unconditionally. DONE never re-launches an access, even though mre/mwe are still high.
- Whenever stallreq_mem=1, wb_we is forced to 0 and wb_wdata to 0 (bubble safety).
- dm_ack is ignored in IDLE and DONE.
- Reset values: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, rdata_q=0, counter=0, dm_err=0. The wb_* outputs follow IDLE pass-through.
- Reset during BUSY drops dm_req on the next edge and the access is never retried. The memory must tolerate an abandoned request.

## Timing
- Any access costs at least 2 stall cycles: the IDLE launch cycle plus a BUSY cycle.
- dm_ack in the k-th BUSY cycle (k≥1) gives k+1 stall cycles, then one DONE cycle with stallreq_mem=0.
- A timeout gives TIMEOUT+1 stall cycles.
- dm_req, dm_we, dm_addr and dm_wdata are stable from launch edge until the cycle dm_ack is sampled.
- Back-to-back accesses: the next instruction appears in IDLE the cycle after DONE, with no extra gap.
- Non-memory instructions: zero latency, fully combinational pass-through.

## Structure
- The shared defines header carries the FSM state encodings (2 bits), ERR_DATA, and the stall-bus bit index for MEM (4).
- Widths use the existing REG_ADDR_BUS, REG_BUS, MEM_BUS and MEM_ADDR_BUS macros.
- One sub-module, mem_timeout_cnt: clear, enable and terminal-count output, with width clog2(TIMEOUT).
- The FSM, request registers and output mux stay in mem_access_stage.

## Test plan
- Reset: assert rst with mem_mre=1 -> dm_req=0, stallreq_mem=0, dm_err=0; after release, the access launches on the first edge.
- Load, ack in first BUSY cycle, dm_rdata=32'h1234_5678, mem_waddr=5'd3, mem_we=1 -> stallreq_mem high for 2 cycles; DONE shows wb_we=1, wb_waddr=3, wb_wdata=32'h1234_5678.
- Store to 32'h0000_0040 with data 32'hA5A5_A5A5, ack after 4 BUSY cycles -> dm_we=1 with address and data stable throughout, 5 stall cycles, and wb_we=0 in DONE.
- ALU instruction (mre=mwe=0, mem_wdata=32'h7) -> wb_wdata=32'h7 the same cycle, stallreq_mem never asserted, dm_req stays 0.
- Load with no ack and TIMEOUT=15 -> 16 stall cycles, wb_wdata=32'hDEAD_BEEF, dm_err=1 held until rst; a late dm_ack in IDLE is ignored.
- Load then store back-to-back, plus rst asserted mid-BUSY in a second run -> two distinct requests, one per instruction, with no relaunch in DONE; after rst, dm_req=0 and no retry.
